// File: rtl/proj_vertex_transform_if.sv
// rtl/proj_vertex_transform_if.sv - matrix/vertex input and clip-vertex output handshake bundle
interface proj_vertex_transform_if #(
  parameter int DW = 16
);
  logic [16*DW-1:0] projMtrx;
  logic [4*DW-1:0]  vtx_in;
  logic             in_valid;
  logic             in_ready;
  logic [4*DW-1:0]  vtx_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output projMtrx, vtx_in, in_valid, out_ready,
    input  in_ready, vtx_out, out_valid
  );

  modport slave (
    input  projMtrx, vtx_in, in_valid, out_ready,
    output in_ready, vtx_out, out_valid
  );
endinterface

// File: rtl/proj_vertex_transform.sv
// rtl/proj_vertex_transform.sv - sequential 4x4 matrix x vertex multiply, one shared MAC over 16 cycles
module proj_vertex_transform #(
  parameter int DW   = 16,
  parameter int FRAC = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  proj_vertex_transform_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int AW = 2*DW + 2;

  localparam logic signed [AW-1:0] SMAX = AW'((64'sd1 <<< (DW-1)) - 64'sd1);
  localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);

  logic [1:0]              state;
  logic [1:0]              row;
  logic [1:0]              col;
  logic signed [AW-1:0]    acc;
  logic [16*DW-1:0]        mtx_r;
  logic [4*DW-1:0]         vtx_r;
  logic [DW-1:0]           r0, r1, r2;
  logic [4*DW-1:0]         vtx_q;
  logic                    ov;

  logic [3:0]              midx;
  logic [1:0]              vidx;
  logic signed [DW-1:0]    m_sel;
  logic signed [DW-1:0]    v_sel;
  logic signed [2*DW-1:0]  prod;
  logic signed [AW-1:0]    acc_next;
  logic signed [AW-1:0]    shifted;
  logic [DW-1:0]           res_sat;

  // Element 0 sits in the top bits of both packed buses, hence the inverted indices.
  always_comb begin
    midx     = ~{row, col};
    vidx     = ~col;
    m_sel    = mtx_r[int'(midx)*DW +: DW];
    v_sel    = vtx_r[int'(vidx)*DW +: DW];
    prod     = m_sel * v_sel;
    acc_next = acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};
    shifted  = acc_next >>> FRAC;
    res_sat  = shifted[DW-1:0];
    if (shifted > SMAX)
      res_sat = {1'b0, {(DW-1){1'b1}}};
    else if (shifted < SMIN)
      res_sat = {1'b1, {(DW-1){1'b0}}};
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = ov;
  assign bus.vtx_out   = vtx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= 2'd0;
      col   <= 2'd0;
      acc   <= '0;
      mtx_r <= '0;
      vtx_r <= '0;
      r0    <= '0;
      r1    <= '0;
      r2    <= '0;
      vtx_q <= '0;
      ov    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mtx_r <= bus.projMtrx;
            vtx_r <= bus.vtx_in;
            row   <= 2'd0;
            col   <= 2'd0;
            acc   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (col == 2'd3) begin
            acc <= '0;
            col <= 2'd0;
            row <= row + 2'd1;
            // Rows 0-2 are parked so vtx_out only moves once, on entry to DONE.
            case (row)
              2'd0: r0 <= res_sat;
              2'd1: r1 <= res_sat;
              2'd2: r2 <= res_sat;
              default: begin
                vtx_q <= {r0, r1, r2, res_sat};
                ov    <= 1'b1;
                state <= DONE;
              end
            endcase
          end else begin
            acc <= acc_next;
            col <= col + 2'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ov    <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_proj_vertex_transform.sv
// tb/tb_proj_vertex_transform.sv - directed bench for proj_vertex_transform
module tb_proj_vertex_transform;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n;

  always #5 clk = ~clk;

  proj_vertex_transform_if #(.DW(16)) bus ();

  proj_vertex_transform #(.DW(16), .FRAC(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [255:0] IDENT = {16'h0020, 16'h0000, 16'h0000, 16'h0000,
                                    16'h0000, 16'h0020, 16'h0000, 16'h0000,
                                    16'h0000, 16'h0000, 16'h0020, 16'h0000,
                                    16'h0000, 16'h0000, 16'h0000, 16'h0020};
  localparam logic [255:0] PROJ  = {16'h0030, 16'h0000, 16'h0000, 16'h0000,
                                    16'h0000, 16'h0040, 16'h0000, 16'h0000,
                                    16'h0000, 16'h0000, 16'h0021, 16'hFABC,
                                    16'h0000, 16'h0000, 16'h0020, 16'h0000};
  localparam logic [255:0] SATM  = {16'h7FFF, 240'h0};
  localparam logic [63:0]  V1    = {16'h0040, 16'hFFE0, 16'h0060, 16'h0020};
  localparam logic [63:0]  V2    = {16'h0040, 16'h0020, 16'h0A00, 16'h0020};
  localparam logic [63:0]  R2    = {16'h0060, 16'h0040, 16'h050C, 16'h0A00};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [255:0] m, input logic [63:0] v);
    int k;
    bus.projMtrx = m;
    bus.vtx_in   = v;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      tick();
      k++;
    end
    chk("in_ready_wait", 64'(k < 40), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("release_out_valid", 64'(bus.out_valid), 64'd0);
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.projMtrx  = '0;
    bus.vtx_in    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_vtx_out", bus.vtx_out, 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // identity
    send(IDENT, V1);
    chk("calc_in_ready", 64'(bus.in_ready), 64'd0);
    wait_out(n);
    chk("latency", 64'(n), 64'd16);
    chk("ident_out", bus.vtx_out, V1);
    chk("done_in_ready", 64'(bus.in_ready), 64'd0);
    release_out();

    // projection matrix
    send(PROJ, V2);
    wait_out(n);
    chk("proj_latency", 64'(n), 64'd16);
    chk("proj_out", bus.vtx_out, R2);
    release_out();

    // saturation, both signs
    send(SATM, {16'h7FFF, 48'h0});
    wait_out(n);
    chk("sat_pos", bus.vtx_out, {16'h7FFF, 48'h0});
    release_out();
    send(SATM, {16'h8001, 48'h0});
    wait_out(n);
    chk("sat_neg", bus.vtx_out, {16'h8000, 48'h0});

    // backpressure: held output stays put
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_vtx_out", bus.vtx_out, {16'h8000, 48'h0});
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    release_out();

    // reset in the 8th CALC cycle
    send(PROJ, V2);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_vtx_out", bus.vtx_out, 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_no_valid", 64'(bus.out_valid), 64'd0);
    end
    send(IDENT, V1);
    wait_out(n);
    chk("after_abort_latency", 64'(n), 64'd16);
    chk("after_abort_out", bus.vtx_out, V1);
    release_out();

    // inputs changed after accept, in_valid held during CALC
    send(IDENT, V1);
    bus.projMtrx = PROJ;
    bus.vtx_in   = V2;
    bus.in_valid = 1'b1;
    wait_out(n);
    bus.in_valid = 1'b0;
    chk("latch_latency", 64'(n), 64'd16);
    chk("latch_out", bus.vtx_out, V1);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
